restoring_div32: RTL

RESTORING_DIV32 -- requirements
Module: restoring_div32

---
 rtl/restoring_div32.sv | 105 ++++++++++
 1 files changed

// File: rtl/restoring_div32.sv
// Restoring unsigned divider, one quotient bit per clock; done pulses WIDTH+1 edges after accept (1 for b==0).
// No backpressure: start is only sampled in IDLE and ignored while busy; results hold until the next completion.
module restoring_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;   // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   rem;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic             neg;
  logic             last;

  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {2'b00, dsr};
    neg     = trial[WIDTH+1];
    rem_nxt = neg ? shifted[WIDTH:0] : trial[WIDTH:0];
    dvd_nxt = {dvd[WIDTH-2:0], ~neg};
    last    = (cnt == CW'(1));
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (b == '0) ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            dvd <= a;
            dsr <= b;
            rem <= '0;
            cnt <= CW'(WIDTH);
            if (b == '0) begin
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt - CW'(1);
          if (last) begin
            quotient    <= dvd_nxt;
            remainder   <= rem_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
